// File: rtl/arb_32b_to_8b_ctrl.sv
// Two-requester round-robin arbiter that captures a 32-bit word
// and emits it as four bytes over a valid/ready lane.
//
// Ports:
//   clk, reset_L              clock, async active-low reset
//   req0_valid/data/ready     requester 0 word handshake
//   req1_valid/data/ready     requester 1 word handshake
//   out_valid/data/ready      8-bit output lane
//   grant                     requester whose word is in flight
//   busy                      high while bytes are being sent
module arb_32b_to_8b_ctrl #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        grant,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic [31:0] word, word_nx;
  logic [1:0]  cnt, cnt_nx;
  logic        grant_nx;
  logic        last, last_nx;

  logic        idle;
  logic        sel;
  logic        acc;
  logic [1:0]  idx;

  assign idle = (state == IDLE);

  // On a tie the requester not served last wins.
  assign sel = (req0_valid & req1_valid) ? ~last : req1_valid;

  // Readies are forced low while reset is held.
  assign req0_ready = reset_L & idle & req0_valid & ~sel;
  assign req1_ready = reset_L & idle & req1_valid & sel;
  assign acc        = req0_ready | req1_ready;

  always_comb begin
    state_nx = state;
    word_nx  = word;
    cnt_nx   = cnt;
    grant_nx = grant;
    last_nx  = last;
    unique case (state)
      IDLE: begin
        if (acc) begin
          word_nx  = sel ? req1_data : req0_data;
          grant_nx = sel;
          last_nx  = sel;
          cnt_nx   = 2'd0;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          cnt_nx = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
      word  <= '0;
      cnt   <= '0;
      grant <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      word  <= word_nx;
      cnt   <= cnt_nx;
      grant <= grant_nx;
      last  <= last_nx;
    end
  end

  // Byte 0 is the top byte when MSB_FIRST, so invert the index.
  assign idx = MSB_FIRST ? ~cnt : cnt;

  assign busy      = (state == SEND);
  assign out_valid = busy;
  assign out_data  = busy ? word[{idx, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_arb_32b_to_8b_ctrl.sv
// Directed table-driven bench for arb_32b_to_8b_ctrl.
// Inputs change on the falling edge; outputs sampled before rising.
module tb_arb_32b_to_8b_ctrl;

  logic        clk;
  logic        reset_L;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        grant;
  logic        busy;

  int checks;
  int failures;

  arb_32b_to_8b_ctrl #(.MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .grant      (grant),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic        r0v;
    logic [31:0] d0;
    logic        r1v;
    logic [31:0] d1;
    logic        ordy;
    logic        e0;
    logic        e1;
    logic        eov;
    logic [7:0]  eod;
    logic        egr;
    logic        ebusy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input bit rst, input logic r0v, input logic [31:0] d0,
    input logic r1v, input logic [31:0] d1, input logic ordy,
    input logic e0, input logic e1, input logic eov,
    input logic [7:0] eod, input logic egr, input logic ebusy);
    vec_t v;
    v.rst = rst; v.r0v = r0v; v.d0 = d0;
    v.r1v = r1v; v.d1 = d1; v.ordy = ordy;
    v.e0 = e0; v.e1 = e1; v.eov = eov;
    v.eod = eod; v.egr = egr; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, ".req0_ready"}, 32'(req0_ready), 32'(v.e0));
    chk({tag, ".req1_ready"}, 32'(req1_ready), 32'(v.e1));
    chk({tag, ".out_valid"},  32'(out_valid),  32'(v.eov));
    chk({tag, ".out_data"},   32'(out_data),   32'(v.eod));
    chk({tag, ".grant"},      32'(grant),      32'(v.egr));
    chk({tag, ".busy"},       32'(busy),       32'(v.ebusy));
  endtask

  // Hold reset 3 cycles with every input high, then release.
  task automatic do_reset();
    reset_L    = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 32'hFFFF_FFFF;
    req1_data  = 32'hFFFF_FFFF;
    out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk_outs("reset", mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 8'h00, 0, 0));
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  // Drive one cycle of inputs, check, then move to the next negedge.
  task automatic apply(input vec_t v, input string tag);
    if (v.rst) do_reset();
    req0_valid = v.r0v;
    req0_data  = v.d0;
    req1_valid = v.r1v;
    req1_data  = v.d1;
    out_ready  = v.ordy;
    #2;
    chk_outs(tag, v);
    @(negedge clk);
  endtask

  localparam logic [31:0] W  = 32'hA1B2_C3D4;
  localparam logic [31:0] R0 = 32'h1111_1111;
  localparam logic [31:0] R1 = 32'h2222_2222;

  initial begin
    logic [31:0] rr [2];
    logic [7:0]  rb [2];
    checks     = 0;
    failures   = 0;
    reset_L    = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    out_ready  = 1'b0;
    rr[0] = R0;
    rr[1] = R1;
    rb[0] = 8'h11;
    rb[1] = 8'h22;

    // Single word, no backpressure.
    add(mk(1, 1, W, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'hA1, 0, 1));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'hB2, 0, 1));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'hC3, 0, 1));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'hD4, 0, 1));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0));

    // Backpressure: B2 held for three cycles.
    add(mk(1, 1, W, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'hA1, 0, 1));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'hB2, 0, 1));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'hB2, 0, 1));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'hB2, 0, 1));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'hC3, 0, 1));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'hD4, 0, 1));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0));

    // Round-robin: grants 0,1,0,1 with a handshake every 5 cycles.
    for (int w = 0; w < 4; w++) begin
      int g;
      g = w % 2;
      add(mk(w == 0, 1, R0, 1, R1, 1,
             g == 0, g == 1, 0, 8'h00,
             (w == 0) ? 1'b0 : 1'(1 - g), 0));
      for (int b = 0; b < 4; b++) begin
        add(mk(0, 1, R0, 1, R1, 1, 0, 0, 1, rb[g], 1'(g), 1));
      end
    end

    // req1 alone, back-to-back words.
    add(mk(1, 0, 0, 1, 32'h0102_0304, 1, 0, 1, 0, 8'h00, 0, 0));
    add(mk(0, 0, 0, 1, 32'h0506_0708, 1, 0, 0, 1, 8'h01, 1, 1));
    add(mk(0, 0, 0, 1, 32'h0506_0708, 1, 0, 0, 1, 8'h02, 1, 1));
    add(mk(0, 0, 0, 1, 32'h0506_0708, 1, 0, 0, 1, 8'h03, 1, 1));
    add(mk(0, 0, 0, 1, 32'h0506_0708, 1, 0, 0, 1, 8'h04, 1, 1));
    add(mk(0, 0, 0, 1, 32'h0506_0708, 1, 0, 1, 0, 8'h00, 1, 0));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h05, 1, 1));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h06, 1, 1));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h07, 1, 1));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h08, 1, 1));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 1, 0));

    @(negedge clk);
    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("v%0d", i));
    end

    // Reset mid-word after req1 has set last=1; then tie must go to req0.
    apply(mk(1, 0, 0, 1, W, 1, 0, 1, 0, 8'h00, 0, 0), "mw0");
    apply(mk(0, 0, 0, 1, W, 1, 0, 0, 1, 8'hA1, 1, 1), "mw1");
    apply(mk(0, 0, 0, 1, W, 1, 0, 0, 1, 8'hB2, 1, 1), "mw2");
    #1;
    chk("mw.pre_data", 32'(out_data), 32'hC3);
    #1;
    reset_L = 1'b0;
    #1;
    chk_outs("mw.async",
             mk(0, 1, W, 1, W, 1, 0, 0, 0, 8'h00, 0, 0));
    @(negedge clk);
    reset_L = 1'b1;
    apply(mk(0, 1, 32'h0A0B_0C0D, 1, R1, 1, 1, 0, 0, 8'h00, 0, 0), "mw3");
    apply(mk(0, 1, R0, 1, R1, 1, 0, 0, 1, 8'h0A, 0, 1), "mw4");
    apply(mk(0, 1, R0, 1, R1, 1, 0, 0, 1, 8'h0B, 0, 1), "mw5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
